openmips_kimweng_sopc: RTL and testbench

- System-on-programmable-chip top level for the OpenMIPS five-stage CPU.
- Instantiates the team's existing CPU core (instruction and data Wishbone masters), UART core and SDRAM controller.
- Implements in this block: a 2-master/4-slave Wishbone arbiter-decoder, a GPIO slave and a byte-serial NOR-flash read controller.
- The CPU boots from flash at 0x3000_0000.

---
 rtl/openmips_kimweng_sopc_pkg.sv | 13 +
 rtl/openmips_kimweng_sopc_if.sv | 10 +
 rtl/openmips_kimweng_sopc_flash_ctrl_wb.sv | 67 ++++++
 rtl/openmips_kimweng_sopc.sv | 114 +++++++++++
 tb/tb_openmips_kimweng_sopc.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/openmips_kimweng_sopc_pkg.sv
// openmips_kimweng_sopc_pkg: shared address map, bus widths, reset levels and flash FSM states
package openmips_kimweng_sopc_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;
  localparam logic RstEnable = 1'b1;
  localparam logic RstDisable = 1'b0;
  localparam logic [3:0] REGION_SDR = 4'h0;
  localparam logic [3:0] REGION_UART = 4'h1;
  localparam logic [3:0] REGION_GPIO = 4'h2;
  localparam logic [3:0] REGION_FLASH = 4'h3;
  typedef enum logic [1:0] {F_IDLE, F_READ, F_ACK} flash_state_e;
endpackage

// File: rtl/openmips_kimweng_sopc_if.sv
// openmips_kimweng_sopc_if: classic Wishbone bus between one master and one slave
interface openmips_kimweng_sopc_if;
  import openmips_kimweng_sopc_pkg::*;
  logic cyc, stb, we, ack;
  logic [WB_SW-1:0] sel;
  logic [WB_AW-1:0] adr;
  logic [WB_DW-1:0] wdat, rdat;
  modport master(output cyc, stb, we, sel, adr, wdat, input ack, rdat);
  modport slave(input cyc, stb, we, sel, adr, wdat, output ack, rdat);
endinterface

// File: rtl/openmips_kimweng_sopc_flash_ctrl_wb.sv
// openmips_kimweng_sopc_flash_ctrl_wb: byte-serial NOR flash reader assembling big-endian words
module openmips_kimweng_sopc_flash_ctrl_wb
  import openmips_kimweng_sopc_pkg::*;
#(
  parameter int FLASH_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  openmips_kimweng_sopc_if.slave bus,
  input  logic [7:0] flash_data_i,
  output logic [31:0] flash_addr_o,
  output logic flash_ce_o,
  output logic flash_oe_o
);
  flash_state_e state;
  logic [1:0] byte_idx;
  logic [3:0] wait_cnt;
  logic unused_bits;
  assign unused_bits = ^{bus.sel, bus.wdat, bus.adr[31:28], bus.adr[1:0]};
  always_ff @(posedge clk)
    if (rst == RstEnable) begin
      state <= F_IDLE;
      byte_idx <= '0;
      wait_cnt <= '0;
      bus.ack <= 1'b0;
      bus.rdat <= '0;
      flash_addr_o <= '0;
      flash_ce_o <= 1'b1;
      flash_oe_o <= 1'b1;
    end else
      case (state)
        F_IDLE: begin
          bus.ack <= bus.cyc & bus.stb & bus.we & ~bus.ack;
          if (bus.cyc && bus.stb && !bus.we) begin
            state <= F_READ;
            byte_idx <= '0;
            wait_cnt <= '0;
            flash_addr_o <= {4'h0, bus.adr[27:2], 2'b00};
            flash_ce_o <= 1'b0;
            flash_oe_o <= 1'b0;
          end
        end
        F_READ:
          if (!bus.cyc) begin
            state <= F_IDLE;
            flash_ce_o <= 1'b1;
            flash_oe_o <= 1'b1;
          end else if (wait_cnt == 4'(FLASH_WAIT - 1)) begin
            wait_cnt <= '0;
            bus.rdat <= {bus.rdat[23:0], flash_data_i};
            if (byte_idx == 2'd3) begin
              state <= F_ACK;
              bus.ack <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              flash_addr_o[1:0] <= byte_idx + 2'd1;
            end
          end else
            wait_cnt <= wait_cnt + 4'd1;
        default: begin
          state <= F_IDLE;
          bus.ack <= 1'b0;
          flash_ce_o <= 1'b1;
          flash_oe_o <= 1'b1;
        end
      endcase
endmodule

// File: rtl/openmips_kimweng_sopc.sv
// openmips_kimweng_sopc: SoC fabric joining CPU Wishbone masters to SDRAM, UART, GPIO, flash and a default slave
module openmips_kimweng_sopc
  import openmips_kimweng_sopc_pkg::*;
#(
  parameter int FLASH_WAIT = 4,
  parameter int GPIO_IN_W = 16
) (
  input  logic clk,
  input  logic rst,
  openmips_kimweng_sopc_if.slave iwb,
  openmips_kimweng_sopc_if.slave dwb,
  openmips_kimweng_sopc_if.master uart_bus,
  openmips_kimweng_sopc_if.master sdr_bus,
  input  logic timer_int,
  input  logic uart_int,
  output logic [5:0] cpu_int,
  input  logic [GPIO_IN_W-1:0] gpio_i,
  output logic [31:0] gpio_o,
  input  logic [7:0] flash_data_i,
  output logic [31:0] flash_addr_o,
  output logic flash_we_o,
  output logic flash_rst_o,
  output logic flash_oe_o,
  output logic flash_ce_o
);
  openmips_kimweng_sopc_if fbus ();
  logic gnt, gnt_q, busy_q;
  logic cyc, stb, we, ack, gpio_ack, dflt_ack, gpio_int;
  logic [WB_SW-1:0] sel;
  logic [WB_AW-1:0] adr;
  logic [WB_DW-1:0] wdat, rdat, gpio_rdat, lane;
  logic [3:0] region;
  logic hit_sdr, hit_uart, hit_gpio, hit_flash, hit_dflt;
  logic [GPIO_IN_W-1:0] sync1, sync2, mask;
  // Owner is held for one extra cycle after its cyc drops so slaves always see an idle gap
  assign gnt = busy_q ? gnt_q : dwb.cyc;
  assign cyc = gnt ? dwb.cyc : iwb.cyc;
  assign stb = gnt ? dwb.stb : iwb.stb;
  assign we = gnt ? dwb.we : iwb.we;
  assign sel = gnt ? dwb.sel : iwb.sel;
  assign adr = gnt ? dwb.adr : iwb.adr;
  assign wdat = gnt ? dwb.wdat : iwb.wdat;
  assign region = adr[31:28];
  assign hit_sdr = region == REGION_SDR;
  assign hit_uart = region == REGION_UART;
  assign hit_gpio = region == REGION_GPIO;
  assign hit_flash = region == REGION_FLASH;
  assign hit_dflt = region > REGION_FLASH;
  assign sdr_bus.cyc = cyc & hit_sdr;
  assign sdr_bus.stb = stb & hit_sdr;
  assign sdr_bus.we = we;
  assign sdr_bus.sel = sel;
  assign sdr_bus.adr = adr;
  assign sdr_bus.wdat = wdat;
  assign uart_bus.cyc = cyc & hit_uart;
  assign uart_bus.stb = stb & hit_uart;
  assign uart_bus.we = we;
  assign uart_bus.sel = sel;
  assign uart_bus.adr = adr;
  assign uart_bus.wdat = wdat;
  assign fbus.cyc = cyc & hit_flash;
  assign fbus.stb = stb & hit_flash;
  assign fbus.we = we;
  assign fbus.sel = sel;
  assign fbus.adr = adr;
  assign fbus.wdat = wdat;
  assign ack = cyc & (hit_sdr ? sdr_bus.ack : hit_uart ? uart_bus.ack : hit_gpio ? gpio_ack :
                      hit_flash ? fbus.ack : dflt_ack);
  assign rdat = hit_sdr ? sdr_bus.rdat : hit_uart ? uart_bus.rdat : hit_gpio ? gpio_rdat :
                hit_flash ? fbus.rdat : '0;
  assign dwb.ack = gnt & ack;
  assign iwb.ack = ~gnt & ack;
  assign dwb.rdat = gnt ? rdat : '0;
  assign iwb.rdat = gnt ? '0 : rdat;
  assign lane = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  assign gpio_int = |(sync2 & mask);
  assign cpu_int = {3'b000, gpio_int, uart_int, timer_int};
  assign flash_we_o = 1'b1;
  assign flash_rst_o = ~rst;
  always_ff @(posedge clk)
    if (rst == RstEnable) begin
      gnt_q <= 1'b0;
      busy_q <= 1'b0;
      sync1 <= '0;
      sync2 <= '0;
      mask <= '0;
      gpio_o <= '0;
      gpio_ack <= 1'b0;
      gpio_rdat <= '0;
      dflt_ack <= 1'b0;
    end else begin
      gnt_q <= gnt;
      busy_q <= cyc;
      sync1 <= gpio_i;
      sync2 <= sync1;
      gpio_ack <= cyc & stb & hit_gpio & ~gpio_ack;
      dflt_ack <= cyc & stb & hit_dflt & ~dflt_ack;
      gpio_rdat <= adr[3:2] == 2'd0 ? WB_DW'(sync2) : adr[3:2] == 2'd1 ? gpio_o :
                   adr[3:2] == 2'd2 ? WB_DW'(mask) : '0;
      if (cyc && stb && we && hit_gpio && !gpio_ack) begin
        if (adr[3:2] == 2'd1) gpio_o <= (gpio_o & ~lane) | (wdat & lane);
        if (adr[3:2] == 2'd2) mask <= wdat[GPIO_IN_W-1:0];
      end
    end
  openmips_kimweng_sopc_flash_ctrl_wb #(.FLASH_WAIT(FLASH_WAIT)) u_flash (
    .clk(clk),
    .rst(rst),
    .bus(fbus),
    .flash_data_i(flash_data_i),
    .flash_addr_o(flash_addr_o),
    .flash_ce_o(flash_ce_o),
    .flash_oe_o(flash_oe_o)
  );
endmodule

// File: tb/tb_openmips_kimweng_sopc.sv
// tb_openmips_kimweng_sopc: directed bench acting as CPU masters, flash model and SDRAM/UART slaves
module tb_openmips_kimweng_sopc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timer_int, uart_int;
  logic [5:0] cpu_int;
  logic [15:0] gpio_i;
  logic [31:0] gpio_o, flash_addr_o, pw, rd;
  logic [7:0] flash_data_i;
  logic flash_we_o, flash_rst_o, flash_oe_o, flash_ce_o;
  logic [31:0] prog [4] = '{32'h3C012000, 32'h34020055, 32'hAC220004, 32'h8C030000};
  logic [31:0] fa [8];
  int fn, ce_low, lat, n, errors = 0, checks = 0;
  bit seen;
  openmips_kimweng_sopc_if iwb ();
  openmips_kimweng_sopc_if dwb ();
  openmips_kimweng_sopc_if uart_bus ();
  openmips_kimweng_sopc_if sdr_bus ();
  always #10 clk = ~clk;
  openmips_kimweng_sopc #(.FLASH_WAIT(4), .GPIO_IN_W(16)) dut (
    .clk(clk), .rst(rst), .iwb(iwb), .dwb(dwb), .uart_bus(uart_bus), .sdr_bus(sdr_bus),
    .timer_int(timer_int), .uart_int(uart_int), .cpu_int(cpu_int), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .flash_data_i(flash_data_i), .flash_addr_o(flash_addr_o), .flash_we_o(flash_we_o),
    .flash_rst_o(flash_rst_o), .flash_oe_o(flash_oe_o), .flash_ce_o(flash_ce_o)
  );
  always_comb begin
    pw = prog[flash_addr_o[3:2]];
    flash_data_i = (flash_ce_o | flash_oe_o) ? 8'hFF : flash_addr_o[1:0] == 2'd0 ? pw[31:24] :
                   flash_addr_o[1:0] == 2'd1 ? pw[23:16] : flash_addr_o[1:0] == 2'd2 ? pw[15:8] : pw[7:0];
  end
  always_ff @(posedge clk) begin
    sdr_bus.ack <= sdr_bus.cyc & sdr_bus.stb & ~sdr_bus.ack;
    sdr_bus.rdat <= 32'h5D5D0000 | {16'h0, sdr_bus.adr[15:0]};
  end
  task automatic drive(input bit d, input bit c, input bit w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d) begin
      dwb.cyc = c; dwb.stb = c; dwb.we = w; dwb.sel = s; dwb.adr = a; dwb.wdat = wd;
    end else begin
      iwb.cyc = c; iwb.stb = c; iwb.we = w; iwb.sel = s; iwb.adr = a; iwb.wdat = wd;
    end
  endtask
  function automatic logic m_ack(input bit d);
    return d ? dwb.ack : iwb.ack;
  endfunction
  task automatic xfer(input bit d, input bit w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] r, output int l);
    @(posedge clk); #1;
    drive(d, 1'b1, w, s, a, wd);
    l = 0; fn = 0; ce_low = 0;
    do begin
      @(posedge clk); #1;
      l++;
      if (!flash_ce_o) begin
        ce_low++;
        if (fn == 0 || fa[fn > 0 ? fn - 1 : 0] !== flash_addr_o) begin
          if (fn < 8) fa[fn] = flash_addr_o;
          fn++;
        end
      end
    end while (!m_ack(d) && l < 100);
    r = d ? dwb.rdat : iwb.rdat;
    drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    #100;
    checks++; if (gpio_o !== 32'h0) begin errors++; $display("FAIL rst_gpio_o: got %h want 0", gpio_o); end
    checks++; if ({flash_ce_o, flash_oe_o, flash_we_o} !== 3'b111) begin errors++; $display("FAIL rst_flash_ctl: got %b want 111", {flash_ce_o, flash_oe_o, flash_we_o}); end
    checks++; if (flash_rst_o !== 1'b0) begin errors++; $display("FAIL rst_flash_rst: got %b want 0", flash_rst_o); end
    checks++; if (cpu_int !== 6'h0) begin errors++; $display("FAIL rst_int: got %b want 0", cpu_int); end
    #95 rst = 1'b0;
    #2;
    checks++; if (flash_rst_o !== 1'b1) begin errors++; $display("FAIL rel_flash_rst: got %b want 1", flash_rst_o); end
  endtask
  task automatic test_boot;
    xfer(0, 0, 4'hF, 32'h30000000, 32'h0, rd, lat);
    checks++; if (lat !== 17) begin errors++; $display("FAIL flash_latency: got %0d want 17", lat); end
    checks++; if (rd !== 32'h3C012000) begin errors++; $display("FAIL boot_word0: got %h want 3c012000", rd); end
    checks++; if (fn !== 4 || fa[0] !== 32'h0 || fa[3] !== 32'h3) begin errors++; $display("FAIL burst_addr0: got n=%0d first=%h last=%h want 4 0 3", fn, fa[0], fa[3]); end
    checks++; if (ce_low !== 17) begin errors++; $display("FAIL ce_low_burst: got %0d want 17", ce_low); end
    @(posedge clk); #1;
    checks++; if ({flash_ce_o, flash_oe_o} !== 2'b11) begin errors++; $display("FAIL ce_release: got %b want 11", {flash_ce_o, flash_oe_o}); end
    xfer(0, 0, 4'hF, 32'h30000004, 32'h0, rd, lat);
    checks++; if (rd !== 32'h34020055 || fa[0] !== 32'h4 || fa[3] !== 32'h7) begin errors++; $display("FAIL boot_word1: got %h first=%h last=%h want 34020055 4 7", rd, fa[0], fa[3]); end
    xfer(0, 0, 4'hF, 32'h30000008, 32'h0, rd, lat);
    checks++; if (rd !== 32'hAC220004) begin errors++; $display("FAIL boot_word2: got %h want ac220004", rd); end
    xfer(1, 1, 4'hF, 32'h20000004, 32'h55, rd, lat);
    checks++; if (lat !== 1 || gpio_o !== 32'h55) begin errors++; $display("FAIL gpio_write: got lat=%0d gpio=%h want 1 00000055", lat, gpio_o); end
  endtask
  task automatic test_gpio_readback;
    gpio_i = 16'hA5A5;
    repeat (3) @(posedge clk);
    xfer(1, 0, 4'hF, 32'h20000000, 32'h0, rd, lat);
    checks++; if (lat !== 1 || rd !== 32'h0000A5A5) begin errors++; $display("FAIL gpio_in_read: got lat=%0d dat=%h want 1 0000a5a5", lat, rd); end
    xfer(1, 1, 4'hF, 32'h20000004, rd, rd, lat);
    checks++; if (gpio_o !== 32'h0000A5A5) begin errors++; $display("FAIL gpio_copy: got %h want 0000a5a5", gpio_o); end
    xfer(1, 1, 4'b0100, 32'h20000004, 32'hFFFFFFFF, rd, lat);
    checks++; if (gpio_o !== 32'h00FFA5A5) begin errors++; $display("FAIL gpio_sel_lane: got %h want 00ffa5a5", gpio_o); end
    xfer(1, 0, 4'hF, 32'h20000004, 32'h0, rd, lat);
    checks++; if (rd !== 32'h00FFA5A5) begin errors++; $display("FAIL gpio_out_read: got %h want 00ffa5a5", rd); end
    xfer(1, 0, 4'hF, 32'h00000100, 32'h0, rd, lat);
    checks++; if (lat !== 1 || rd !== 32'h5D5D0100) begin errors++; $display("FAIL sdram_route: got lat=%0d dat=%h want 1 5d5d0100", lat, rd); end
  endtask
  task automatic test_arbiter;
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 4'hF, 32'h20000004, 32'h0);
    drive(0, 1'b1, 1'b0, 4'hF, 32'h20000000, 32'h0);
    n = 0; seen = 0;
    do begin @(posedge clk); #1; n++; if (iwb.ack) seen = 1; end while (!dwb.ack && n < 20);
    checks++; if (n !== 1 || dwb.rdat !== 32'h00FFA5A5 || iwb.rdat !== 32'h0) begin errors++; $display("FAIL arb_data_first: got n=%0d d=%h i=%h want 1 00ffa5a5 0", n, dwb.rdat, iwb.rdat); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL arb_other_ack: got %b want 0", seen); end
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!iwb.ack && n < 20);
    checks++; if (iwb.ack !== 1'b1 || iwb.rdat !== 32'h0000A5A5) begin errors++; $display("FAIL arb_instr_next: got ack=%b dat=%h want 1 0000a5a5", iwb.ack, iwb.rdat); end
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10000010, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 4'hF, 32'h20000000, 32'h0);
    repeat (3) @(posedge clk); #1;
    checks++; if (uart_bus.cyc !== 1'b1 || uart_bus.adr !== 32'h10000010 || dwb.ack !== 1'b0) begin errors++; $display("FAIL arb_lock: got cyc=%b adr=%h dack=%b want 1 10000010 0", uart_bus.cyc, uart_bus.adr, dwb.ack); end
    uart_bus.ack = 1'b1; uart_bus.rdat = 32'hCAFE0001;
    #1;
    checks++; if (iwb.ack !== 1'b1 || iwb.rdat !== 32'hCAFE0001 || dwb.ack !== 1'b0) begin errors++; $display("FAIL uart_route: got ack=%b dat=%h dack=%b want 1 cafe0001 0", iwb.ack, iwb.rdat, dwb.ack); end
    @(posedge clk); #1;
    uart_bus.ack = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!dwb.ack && n < 20);
    checks++; if (dwb.ack !== 1'b1 || dwb.rdat !== 32'h0000A5A5) begin errors++; $display("FAIL arb_handover: got ack=%b dat=%h want 1 0000a5a5", dwb.ack, dwb.rdat); end
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask
  task automatic test_unmapped;
    xfer(1, 0, 4'hF, 32'h40000000, 32'h0, rd, lat);
    checks++; if (lat !== 1 || rd !== 32'h0) begin errors++; $display("FAIL dflt_read: got lat=%0d dat=%h want 1 0", lat, rd); end
    xfer(1, 1, 4'hF, 32'h20000004, rd, rd, lat);
    checks++; if (gpio_o !== 32'h0) begin errors++; $display("FAIL dflt_store: got %h want 0", gpio_o); end
    xfer(1, 1, 4'hF, 32'hF0000000, 32'h123, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dflt_write_ack: got %0d want 1", lat); end
    xfer(0, 0, 4'hF, 32'h3000000C, 32'h0, rd, lat);
    checks++; if (lat !== 17 || rd !== 32'h8C030000) begin errors++; $display("FAIL fetch_continues: got lat=%0d dat=%h want 17 8c030000", lat, rd); end
  endtask
  task automatic test_flash;
    xfer(1, 1, 4'hF, 32'h30000000, 32'hDEAD, rd, lat);
    checks++; if (lat !== 1 || ce_low !== 0) begin errors++; $display("FAIL flash_write_ignored: got lat=%0d ce_low=%0d want 1 0", lat, ce_low); end
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 4'hF, 32'h30000004, 32'h0);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (iwb.ack) seen = 1; end
    checks++; if (flash_ce_o !== 1'b0) begin errors++; $display("FAIL abort_midburst_ce: got %b want 0", flash_ce_o); end
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) begin @(posedge clk); #1; if (iwb.ack) seen = 1; end
    checks++; if (flash_ce_o !== 1'b1 || seen !== 1'b0) begin errors++; $display("FAIL abort_idle: got ce=%b ack_seen=%b want 1 0", flash_ce_o, seen); end
    xfer(0, 0, 4'hF, 32'h30000004, 32'h0, rd, lat);
    checks++; if (lat !== 17 || rd !== 32'h34020055) begin errors++; $display("FAIL after_abort: got lat=%0d dat=%h want 17 34020055", lat, rd); end
  endtask
  task automatic test_interrupt;
    gpio_i = 16'h0000;
    xfer(1, 1, 4'hF, 32'h20000008, 32'h1, rd, lat);
    xfer(1, 0, 4'hF, 32'h20000008, 32'h0, rd, lat);
    checks++; if (lat !== 1 || rd !== 32'h1) begin errors++; $display("FAIL mask_read: got lat=%0d dat=%h want 1 1", lat, rd); end
    checks++; if (cpu_int[2] !== 1'b0) begin errors++; $display("FAIL int_idle: got %b want 0", cpu_int[2]); end
    gpio_i = 16'h0001;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cpu_int[2] && n < 10);
    checks++; if (cpu_int[2] !== 1'b1 || n > 3) begin errors++; $display("FAIL int_latency: got int=%b cycles=%0d want 1 <=3", cpu_int[2], n); end
    xfer(1, 1, 4'hF, 32'h20000004, 32'hFF, rd, lat);
    checks++; if (gpio_o !== 32'hFF) begin errors++; $display("FAIL handler_write: got %h want 000000ff", gpio_o); end
    timer_int = 1'b1; uart_int = 1'b1;
    #1;
    checks++; if (cpu_int !== 6'b000111) begin errors++; $display("FAIL int_vector: got %b want 000111", cpu_int); end
    timer_int = 1'b0; uart_int = 1'b0;
    gpio_i = 16'h0002;
    repeat (3) @(posedge clk); #1;
    checks++; if (cpu_int[2] !== 1'b0) begin errors++; $display("FAIL int_masked: got %b want 0", cpu_int[2]); end
  endtask
  task automatic test_reset_mid;
    gpio_i = 16'h0001;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 4'hF, 32'h30000000, 32'h0);
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (iwb.ack) seen = 1; end
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (iwb.ack) seen = 1; end
    checks++; if (flash_ce_o !== 1'b1 || gpio_o !== 32'h0 || cpu_int !== 6'h0) begin errors++; $display("FAIL rst_mid_state: got ce=%b gpio=%h int=%b want 1 0 0", flash_ce_o, gpio_o, cpu_int); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_noack: got %b want 0", seen); end
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b0;
    xfer(0, 0, 4'hF, 32'h30000000, 32'h0, rd, lat);
    checks++; if (lat !== 17 || rd !== 32'h3C012000) begin errors++; $display("FAIL rst_mid_reboot: got lat=%0d dat=%h want 17 3c012000", lat, rd); end
    checks++; if (cpu_int[2] !== 1'b0) begin errors++; $display("FAIL rst_mask_clear: got %b want 0", cpu_int[2]); end
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: run exceeded 50 us");
    $fatal(1);
  end
  initial begin
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    uart_bus.ack = 1'b0; uart_bus.rdat = 32'h0;
    gpio_i = 16'h0; timer_int = 1'b0; uart_int = 1'b0;
    test_reset;
    test_boot;
    test_gpio_readback;
    test_arbiter;
    test_unmapped;
    test_flash;
    test_interrupt;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
